// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Shift-and-add sequencer for an unsigned WIDTH x WIDTH -> 2*WIDTH multiply.
//   Drives an external combinational adder (AddA + AddB -> AddSoma) and owns the
//   multiplicand register, the {C,HI,LO} accumulator/multiplier shift register,
//   the iteration counter and the control FSM.
//
//   Build option:
//     ADD_SKIP_EN  when defined, iterations whose multiplier bit is 0 skip the ADD
//                  state (latency WIDTH + popcount(Multiplicador) edges). When not
//                  defined every iteration is ADD+SHIFT (latency 2*WIDTH edges).
//                  The product is identical in both builds.
//
//   Ports:
//     clk            rising-edge clock
//     rst            synchronous active-high reset
//     St             start request, accepted only while Idle=1
//     Multiplicando  operand M, captured on the accepting edge
//     Multiplicador  operand Q, captured on the accepting edge
//     Produto        {HI,LO}; valid while Done=1, held while idle
//     Done           one-cycle completion pulse
//     Idle           high only in the idle state
//     AddA           adder operand A = HI
//     AddB           adder operand B = LO[0] ? M : 0
//     AddSoma        adder sum (WIDTH+1 bits, carry in MSB), same cycle

module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 St,
    input  logic [WIDTH-1:0]     Multiplicando,
    input  logic [WIDTH-1:0]     Multiplicador,
    output logic [2*WIDTH-1:0]   Produto,
    output logic                 Done,
    output logic                 Idle,
    output logic [WIDTH-1:0]     AddA,
    output logic [WIDTH-1:0]     AddB,
    input  logic [WIDTH:0]       AddSoma
);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StShift,
        StDone
    } state_e;

    localparam logic [CNTW-1:0] LastIter = CNTW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  m_q, m_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              c_q, c_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        c_d     = c_q;
        cnt_d   = cnt_q;

        case (state_q)
            StIdle: begin
                if (St) begin
                    m_d     = Multiplicando;
                    lo_d    = Multiplicador;
                    hi_d    = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = StAdd;
`ifdef ADD_SKIP_EN
                    // First multiplier bit is 0: nothing to add
                    if (!Multiplicador[0]) begin
                        state_d = StShift;
                    end
`endif
                end
            end

            StAdd: begin
                // AddB is zero when LO[0]=0, so HI passes through unchanged
                {c_d, hi_d} = AddSoma;
                state_d     = StShift;
            end

            StShift: begin
                // {C,HI,LO} shifted right by one, zero into C
                c_d   = 1'b0;
                hi_d  = {c_q, hi_q[WIDTH-1:1]};
                lo_d  = {hi_q[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = StDone;
                end else begin
                    state_d = StAdd;
`ifdef ADD_SKIP_EN
                    // lo_q[1] becomes LO[0] after this shift
                    if (!lo_q[1]) begin
                        state_d = StShift;
                    end
`endif
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs
    always_comb begin
        Produto = {hi_q, lo_q};
        Done    = (state_q == StDone);
        Idle    = (state_q == StIdle);
        AddA    = hi_q;
        AddB    = lo_q[0] ? m_q : '0;
    end

endmodule
